// File: rtl/run_led_sequencer.sv
// Running-LED sequencer: one shared step counter drives a one-hot LED vector.
// Optional RUN_LED_BOUNCE_EN turns wrap-around stepping into ping-pong stepping.
module run_led_sequencer #(
    parameter logic [22:0] STEP_CYCLES = 23'd5_000_000,
    parameter int          LED_NUM     = 4,
    parameter int          POS_W       = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               En_Sig,
    input  logic               Dir_Sig,
    output logic               Step_Tick,
    output logic [POS_W-1:0]   Pos_Out,
    output logic [LED_NUM-1:0] LED_Out
);

    localparam logic [22:0]        COUNT_LAST = STEP_CYCLES - 23'd1;
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0]   POS_ZERO   = '0;
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
    localparam logic [LED_NUM-1:0] LED_ONE    = {{(LED_NUM-1){1'b0}}, 1'b1};

    logic [22:0]      count_q;
    logic [22:0]      count_nxt;
    logic [POS_W-1:0] pos_nxt;
    logic             step_edge;
    logic             going_down;

    assign step_edge = En_Sig && (count_q == COUNT_LAST);

`ifdef RUN_LED_BOUNCE_EN
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    dir_t dir_q;
    dir_t dir_nxt;
    logic unused_dir_sig;

    // Ping-pong mode steers from its own direction register; Dir_Sig is ignored.
    assign unused_dir_sig = Dir_Sig;
    assign going_down     = (dir_q == DIR_DOWN);

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pos_nxt = Pos_Out;
        dir_nxt = dir_q;
        if (!going_down) begin
            if (Pos_Out == POS_LAST) begin
                pos_nxt = Pos_Out - POS_ONE;
                dir_nxt = DIR_DOWN;
            end else begin
                pos_nxt = Pos_Out + POS_ONE;
            end
        end else begin
            if (Pos_Out == POS_ZERO) begin
                pos_nxt = POS_ONE;
                dir_nxt = DIR_UP;
            end else begin
                pos_nxt = Pos_Out - POS_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dir_q <= DIR_UP;
        end else if (step_edge) begin
            dir_q <= dir_nxt;
        end
    end
`else
    assign going_down = Dir_Sig;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pos_nxt = Pos_Out;
        if (!going_down) begin
            // Explicit wrap compare: LED_NUM need not be a power of two.
            pos_nxt = (Pos_Out == POS_LAST) ? POS_ZERO : Pos_Out + POS_ONE;
        end else begin
            pos_nxt = (Pos_Out == POS_ZERO) ? POS_LAST : Pos_Out - POS_ONE;
        end
    end
`endif

    always_comb begin
        count_nxt = count_q;
        if (step_edge) begin
            count_nxt = '0;
        end else if (En_Sig) begin
            count_nxt = count_q + 23'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q   <= '0;
            Step_Tick <= 1'b0;
            Pos_Out   <= POS_ZERO;
            LED_Out   <= LED_ONE;
        end else begin
            count_q   <= count_nxt;
            Step_Tick <= step_edge;
            if (step_edge) begin
                Pos_Out <= pos_nxt;
                LED_Out <= LED_ONE << pos_nxt;
            end
        end
    end

endmodule
